// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge: FSM state encoding and the
// default ACCESS-phase timeout.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int APB_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/apb_wait_counter.sv
// Counts consecutive ACCESS cycles with PREADY low and flags the cycle that
// exhausts the timeout budget. A TIMEOUT_CYCLES of 0 never expires.
module apb_wait_counter
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic ENABLED = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] count_q;

  // Saturates at all-ones so a disabled timeout can wait forever without wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + CW'(1);
    end
  end

  // Combinational so the FSM leaves ACCESS on the same edge the count reaches the limit.
  assign expired = ENABLED && inc && (count_q >= LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Bridges single CPU load/store requests onto an APB bus through an
// IDLE/SETUP/ACCESS/RESP sequence with misalignment and timeout errors.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  apb_state_e  state_q;
  logic [31:0] paddr_q;
  logic [31:0] pwdata_q;
  logic [31:0] resp_rdata_q;
  logic        pwrite_q;
  logic        psel_q;
  logic        penable_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic        req_ready_q;
  logic        req_aligned;
  logic        wait_clr;
  logic        wait_inc;
  logic        wait_expired;

  assign req_aligned = (req_addr[1:0] == 2'b00);
  assign wait_clr    = (state_q == IDLE) && req_valid && req_aligned;
  assign wait_inc    = (state_q == ACCESS) && !PREADY;

  apb_wait_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (wait_clr),
    .inc    (wait_inc),
    .expired(wait_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pwrite_q     <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_aligned) begin
            paddr_q     <= req_addr;
            pwdata_q    <= req_wdata;
            pwrite_q    <= req_write;
            psel_q      <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= SETUP;
          end else if (req_valid) begin
            // Misaligned requests are answered with an error and never reach the bus.
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
            req_ready_q  <= 1'b0;
            state_q      <= RESP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            resp_rdata_q <= (!pwrite_q && !PSLVERR) ? PRDATA : '0;
            resp_err_q   <= PSLVERR;
            resp_valid_q <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            state_q      <= RESP;
          end else if (wait_expired) begin
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            state_q      <= RESP;
          end
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = pwrite_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus random
// transfers checked against a behavioural slave/latency model.
module tb_apb_master_bridge;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [logic [31:0]];

  int          obsLat;
  int          obsSetupAt;
  int          obsAccessAt;
  int          obsAccessCycles;
  logic [31:0] obsRdata;
  logic        obsErr;
  logic        obsStable;
  logic        obsPselSeen;
  logic        obsGot;
  logic        obsReadyAtResp;
  logic        obsPselAtResp;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  // Issues one request and plays an APB slave that stalls `waits` ACCESS cycles;
  // latencies are counted in cycles after the accept edge.
  task automatic run_transfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input int waits, input logic slverr, input logic [31:0] sdata);
    int cyc;
    int acc;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_write = 1'($urandom_range(0, 1));
    cyc = 0; acc = 0;
    obsGot = 1'b0; obsStable = 1'b1; obsPselSeen = 1'b0; obsSetupAt = -1; obsAccessAt = -1;
    obsLat = -1; obsRdata = '0; obsErr = 1'b0; obsReadyAtResp = 1'b0; obsPselAtResp = 1'b0;
    while (!obsGot && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (PSEL === 1'b1) begin
        if (!obsPselSeen) obsSetupAt = cyc;
        obsPselSeen = 1'b1;
        if (PADDR !== addr || PWDATA !== wdata || PWRITE !== wr) obsStable = 1'b0;
      end
      if (PSEL === 1'b1 && PENABLE === 1'b1) begin
        if (obsAccessAt < 0) obsAccessAt = cyc;
        PREADY  = (acc >= waits);
        PSLVERR = PREADY ? slverr : 1'b0;
        PRDATA  = PREADY ? sdata : $urandom;
        acc++;
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
      end
      if (resp_valid === 1'b1) begin
        obsGot = 1'b1; obsLat = cyc; obsRdata = resp_rdata; obsErr = resp_err;
        obsReadyAtResp = req_ready; obsPselAtResp = PSEL;
      end
    end
    obsAccessCycles = acc;
    PREADY = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b expected 000", {PSEL, PENABLE, PWRITE}); end
    checks++; if (PADDR !== 32'h0 || PWDATA !== 32'h0) begin errors++; $display("FAIL reset_bus: got %h/%h expected 0/0", PADDR, PWDATA); end
    checks++; if ({resp_valid, resp_err} !== 2'b00 || resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp: got v=%b e=%b d=%h expected zeros", resp_valid, resp_err, resp_rdata); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_store;
    run_transfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h5555_AAAA);
    checks++; if (obsSetupAt !== 1 || obsAccessAt !== 2) begin errors++; $display("FAIL store_phases: got setup=%0d access=%0d expected 1/2", obsSetupAt, obsAccessAt); end
    checks++; if (obsStable !== 1'b1) begin errors++; $display("FAIL store_bus: got stable=%b expected 1", obsStable); end
    checks++; if (obsLat !== 3) begin errors++; $display("FAIL store_latency: got %0d expected 3", obsLat); end
    checks++; if (obsErr !== 1'b0 || obsRdata !== 32'h0) begin errors++; $display("FAIL store_resp: got e=%b d=%h expected 0/0", obsErr, obsRdata); end
    checks++; if (obsReadyAtResp !== 1'b0 || obsPselAtResp !== 1'b0) begin errors++; $display("FAIL store_resp_ctrl: got ready=%b psel=%b expected 0/0", obsReadyAtResp, obsPselAtResp); end
    mem[32'h10] = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL store_after: got v=%b ready=%b expected 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_load;
    run_transfer(1'b0, 32'h0000_0010, 32'h0BAD_F00D, 0, 1'b0, mem[32'h10]);
    checks++; if (obsLat !== 3) begin errors++; $display("FAIL load_latency: got %0d expected 3", obsLat); end
    checks++; if (obsRdata !== 32'hDEAD_BEEF || obsErr !== 1'b0) begin errors++; $display("FAIL load_resp: got d=%h e=%b expected deadbeef/0", obsRdata, obsErr); end
    @(negedge clk);
    checks++; if (resp_rdata !== 32'hDEAD_BEEF || resp_valid !== 1'b0) begin errors++; $display("FAIL load_hold: got d=%h v=%b expected deadbeef/0", resp_rdata, resp_valid); end
  endtask

  task automatic test_wait_err;
    run_transfer(1'b0, 32'h0000_0020, 32'h1111_2222, 3, 1'b1, 32'h1234_5678);
    checks++; if (obsStable !== 1'b1) begin errors++; $display("FAIL wait_bus: got stable=%b expected 1", obsStable); end
    checks++; if (obsLat !== 6) begin errors++; $display("FAIL wait_latency: got %0d expected 6", obsLat); end
    checks++; if (obsErr !== 1'b1 || obsRdata !== 32'h0) begin errors++; $display("FAIL wait_resp: got e=%b d=%h expected 1/0", obsErr, obsRdata); end
  endtask

  task automatic test_timeout;
    run_transfer(1'b0, 32'h0000_0030, 32'h0, 1000, 1'b0, 32'hCAFE_0001);
    checks++; if (obsAccessCycles !== TIMEOUT || obsLat !== TIMEOUT + 2) begin errors++; $display("FAIL timeout_len: got acc=%0d lat=%0d expected %0d/%0d", obsAccessCycles, obsLat, TIMEOUT, TIMEOUT + 2); end
    checks++; if (obsErr !== 1'b1 || obsRdata !== 32'h0) begin errors++; $display("FAIL timeout_resp: got e=%b d=%h expected 1/0", obsErr, obsRdata); end
    @(negedge clk);
    checks++; if (PSEL !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL timeout_idle: got psel=%b ready=%b expected 0/1", PSEL, req_ready); end
    // One wait short of the limit still completes normally.
    run_transfer(1'b0, 32'h0000_0034, 32'h0, TIMEOUT - 1, 1'b0, 32'hCAFE_0002);
    checks++; if (obsLat !== TIMEOUT + 2 || obsErr !== 1'b0 || obsRdata !== 32'hCAFE_0002) begin errors++; $display("FAIL timeout_edge: got lat=%0d e=%b d=%h expected %0d/0/cafe0002", obsLat, obsErr, obsRdata, TIMEOUT + 2); end
  endtask

  task automatic test_misaligned;
    run_transfer(1'b0, 32'h0000_0013, 32'h0, 0, 1'b0, 32'h7777_7777);
    checks++; if (obsPselSeen !== 1'b0) begin errors++; $display("FAIL misalign_psel: got %b expected 0", obsPselSeen); end
    checks++; if (obsLat !== 1 || obsErr !== 1'b1 || obsRdata !== 32'h0) begin errors++; $display("FAIL misalign_resp: got lat=%0d e=%b d=%h expected 1/1/0", obsLat, obsErr, obsRdata); end
    @(negedge clk);
    run_transfer(1'b1, 32'h0000_0042, 32'h1, 0, 1'b0, 32'h0);
    checks++; if (obsPselSeen !== 1'b0 || obsLat !== 1 || obsErr !== 1'b1) begin errors++; $display("FAIL misalign_store: got psel=%b lat=%0d e=%b expected 0/1/1", obsPselSeen, obsLat, obsErr); end
  endtask

  task automatic test_reset_mid_access;
    bit sawResp;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0040; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    PREADY = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin errors++; $display("FAIL midrst_access: got psel=%b pen=%b expected 1/1", PSEL, PENABLE); end
    #1 rst = 1'b1;
    #1;
    checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PADDR !== 32'h0) begin errors++; $display("FAIL midrst_async: got psel=%b pen=%b addr=%h expected 0/0/0", PSEL, PENABLE, PADDR); end
    sawResp = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) sawResp = 1'b1;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || PSEL !== 1'b0) begin errors++; $display("FAIL midrst_release: got ready=%b psel=%b expected 1/0", req_ready, PSEL); end
    @(negedge clk);
    if (resp_valid !== 1'b0) sawResp = 1'b1;
    checks++; if (sawResp !== 1'b0) begin errors++; $display("FAIL midrst_noresp: got pulse=%b expected 0", sawResp); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      logic        wr;
      logic        slverr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] sdata;
      int          waits;
      int          expLat;
      logic        expErr;
      logic        expPsel;
      logic [31:0] expRdata;
      wr     = 1'($urandom_range(0, 1));
      addr   = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 5) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      wdata  = $urandom;
      waits  = ($urandom_range(0, 5) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 3) : $urandom_range(0, 4);
      slverr = ($urandom_range(0, 3) == 0);
      sdata  = mem.exists(addr) ? mem[addr] : ~addr;
      if (addr[1:0] != 2'b00) begin
        expLat = 1; expErr = 1'b1; expRdata = '0; expPsel = 1'b0;
      end else if (waits >= TIMEOUT) begin
        expLat = TIMEOUT + 2; expErr = 1'b1; expRdata = '0; expPsel = 1'b1;
      end else begin
        expLat = 3 + waits; expErr = slverr; expPsel = 1'b1;
        expRdata = (wr || slverr) ? 32'h0 : sdata;
        if (wr && !slverr) mem[addr] = wdata;
      end
      run_transfer(wr, addr, wdata, waits, slverr, sdata);
      checks++; if (obsLat !== expLat || obsPselSeen !== expPsel) begin errors++; $display("FAIL rand%0d_timing: got lat=%0d psel=%b expected %0d/%b", i, obsLat, obsPselSeen, expLat, expPsel); end
      checks++; if (obsErr !== expErr || obsRdata !== expRdata) begin errors++; $display("FAIL rand%0d_resp: got e=%b d=%h expected %b/%h", i, obsErr, obsRdata, expErr, expRdata); end
      checks++; if (obsStable !== 1'b1) begin errors++; $display("FAIL rand%0d_bus: got stable=%b expected 1", i, obsStable); end
    end
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0; rst = 1'b1;
    test_reset();
    test_store();
    test_load();
    test_wait_err();
    test_timeout();
    test_misaligned();
    test_reset_mid_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the consecutive ACCESS cycles with PREADY=0 before abort; 0 disables the timeout.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  CPU load/store request present.
REQ-005 SHALL have port req_ready  output  1  bridge accepts a request this cycle.
REQ-006 SHALL have port req_write  input  1  1=store, 0=load.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data.
REQ-009 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata  output  32  load data; 0 for stores and errors.
REQ-011 SHALL have port resp_err  output  1  slave error, timeout or misalignment; valid with resp_valid.
REQ-012 SHALL have APB ports PSEL, PENABLE, PWRITE (output, 1 bit each), PADDR and PWDATA (output, 32 bits each), PRDATA (input, 32 bits), PREADY and PSLVERR (input, 1 bit each), with standard APB meaning.

Function
REQ-013 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP.
REQ-014 In IDLE: req_ready=1, PSEL=0, PENABLE=0.
- req_valid=1 with req_addr[1:0]=0 latches addr/wdata/write into PADDR/PWDATA/PWRITE and goes to SETUP.
- req_valid=1 with req_addr[1:0]!=0 goes to RESP with error set and starts no APB transfer.
REQ-015 In SETUP: PSEL=1, PENABLE=0, req_ready=0; always advances to ACCESS next cycle.
REQ-016 In ACCESS: PSEL=1, PENABLE=1; PADDR, PWDATA and PWRITE SHALL stay unchanged from SETUP.
REQ-017 In ACCESS with PREADY=1: register PRDATA if the access is a load (0 if a store), register PSLVERR as the error, go to RESP.
REQ-018 In ACCESS with PREADY=0: increment the wait counter; when the counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES!=0), go to RESP with error=1 and rdata=0.
REQ-019 Wait counter: 5 bits minimum, sized to hold TIMEOUT_CYCLES, cleared on entry to SETUP, never wraps.
REQ-020 PRDATA SHALL be sampled only in ACCESS with PREADY=1, because the slave drives Z otherwise.
REQ-021 In RESP: resp_valid=1 for exactly one cycle, req_ready=0, PSEL=0; then return to IDLE.
REQ-022 Zero-wait latency: accept at T, SETUP at T+1, ACCESS at T+2, resp_valid at T+3, req_ready at T+4.
- Maximum throughput is one transfer per 4 cycles.
REQ-023 req_valid while req_ready=0 SHALL be ignored; the requester holds the request.
REQ-024 resp_rdata and resp_err SHALL hold their last values outside RESP; consumers qualify them with resp_valid.
REQ-025 PADDR, PWDATA and PWRITE SHALL hold their last values in IDLE and RESP.

Reset
REQ-026 rst=1 SHALL immediately and asynchronously force state IDLE and drive:
- PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0;
- resp_valid=0, resp_rdata=0, resp_err=0;
- wait counter=0.
REQ-027 Reset during SETUP, ACCESS or RESP SHALL abort the transfer with no resp_valid pulse.
REQ-028 req_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-029 Package apb_pkg SHALL hold the FSM state encoding (2 bits) and the constant APB_TIMEOUT_DEFAULT=16.
REQ-030 Sub-module apb_wait_counter SHALL implement the wait counter.
- Inputs: clr, inc.
- Output: expired.
- Parameter: TIMEOUT_CYCLES.
REQ-031 Everything else in apb_master_bridge SHALL be a single always block for state plus registered outputs.

Verification
REQ-032 Store: req_write=1, addr 0x0000_0010, wdata 0xDEAD_BEEF, PREADY=1.
- SETUP at T+1, ACCESS at T+2 with PADDR=0x10 and PWDATA=0xDEADBEEF.
- resp_valid at T+3 with resp_err=0 and resp_rdata=0.
REQ-033 Load after that store, same address, slave returns 0xDEADBEEF in ACCESS: resp_rdata=0xDEADBEEF and resp_err=0 at T+3.
REQ-034 Load with PREADY=0 for 3 ACCESS cycles then 1, PSLVERR=1: PADDR stable throughout, resp_valid at T+6 with resp_err=1.
REQ-035 PREADY held 0 with TIMEOUT_CYCLES=16: after 16 ACCESS cycles, resp_valid=1, resp_err=1, resp_rdata=0; next cycle IDLE with PSEL=0.
REQ-036 Misaligned addr 0x0000_0013: PSEL never asserts; resp_valid at T+1 with resp_err=1.
REQ-037 rst asserted mid-ACCESS: PSEL=0 and PENABLE=0 within the same cycle, no resp_valid, and req_ready=1 after release.
